// File: rtl/sp_seq_unit_if.sv
// Decoder/memory-side bundle for the stack-pointer unit.
// Master drives the request; slave returns SP, address and beats.
interface sp_seq_unit_if #(
  parameter int DATA_W = 32,
  parameter int NREG   = 8
);
  localparam int IDX_W = (NREG > 1) ? $clog2(NREG) : 1;

  logic              start;
  logic [7:0]        op_sel;
  logic [NREG-1:0]   reg_list;
  logic [6:0]        immed7;
  logic [7:0]        immed8;
  logic [DATA_W-1:0] data_in;
  logic [DATA_W-1:0] sp_out;
  logic [DATA_W-1:0] addr_out;
  logic [DATA_W-1:0] mem_addr;
  logic              mem_we;
  logic              mem_re;
  logic [IDX_W-1:0]  mem_reg_idx;
  logic              busy;
  logic              done;
  logic              fault;

  modport master (
    output start, op_sel, reg_list, immed7, immed8, data_in,
    input  sp_out, addr_out, mem_addr, mem_we, mem_re,
    input  mem_reg_idx, busy, done, fault
  );

  modport slave (
    input  start, op_sel, reg_list, immed7, immed8, data_in,
    output sp_out, addr_out, mem_addr, mem_we, mem_re,
    output mem_reg_idx, busy, done, fault
  );
endinterface

// File: rtl/sp_seq_unit.sv
// Registered stack pointer with multi-beat PUSH/POP sequencing,
// SP-relative address generation and stack bound checking.
module sp_seq_unit #(
  parameter int              DATA_W      = 32,
  parameter int              NREG        = 8,
  parameter logic [DATA_W-1:0] SP_RESET    = 'h100,
  parameter logic [DATA_W-1:0] STACK_BASE  = 'h100,
  parameter logic [DATA_W-1:0] STACK_LIMIT = 'h080
) (
  input logic         clk,
  input logic         rst_n,
  sp_seq_unit_if.slave bus
);
  localparam int IDX_W = (NREG > 1) ? $clog2(NREG) : 1;
  localparam int CNT_W = $clog2(NREG + 1);

  typedef enum logic [1:0] {
    IDLE,
    PUSH_SEQ,
    POP_SEQ
  } state_t;

  state_t            state;
  logic [DATA_W-1:0] sp;
  logic [DATA_W-1:0] addr;
  logic [DATA_W-1:0] maddr;
  logic [DATA_W-1:0] pend_sp;
  logic [IDX_W-1:0]  idx;
  logic [NREG-1:0]   rem;
  logic              we;
  logic              re;
  logic              bsy;
  logic              dn;
  logic              flt;

  logic [CNT_W-1:0]  n;
  logic [DATA_W:0]   span;
  logic [DATA_W:0]   dec;
  logic [DATA_W:0]   inc;
  logic              push_bad;
  logic              pop_bad;
  logic [DATA_W-1:0] off7;
  logic [DATA_W-1:0] off8;
  logic [IDX_W-1:0]  first_idx;
  logic [IDX_W-1:0]  rem_idx;
  logic [NREG-1:0]   list_rest;
  logic [NREG-1:0]   rem_rest;
  logic              unused_ok;

  function automatic logic [CNT_W-1:0] popcnt(
    input logic [NREG-1:0] m
  );
    popcnt = '0;
    for (int i = 0; i < NREG; i++)
      popcnt = popcnt + CNT_W'(m[i]);
  endfunction

  function automatic logic [IDX_W-1:0] low_idx(
    input logic [NREG-1:0] m
  );
    low_idx = '0;
    for (int i = NREG - 1; i >= 0; i--)
      if (m[i]) low_idx = IDX_W'(i);
  endfunction

  // Bound checks, offsets and next-register selection
  always_comb begin
    n         = popcnt(bus.reg_list);
    span      = '0;
    span[CNT_W+1:0] = {n, 2'b00};
    dec       = {1'b0, sp} - span;
    inc       = {1'b0, sp} + span;
    push_bad  = dec[DATA_W] ||
                (dec[DATA_W-1:0] < STACK_LIMIT);
    pop_bad   = inc[DATA_W] ||
                (inc[DATA_W-1:0] > STACK_BASE);
    off7      = {{(DATA_W-7){1'b0}},
                 bus.immed7[4:0], 2'b00};
    off8      = {{(DATA_W-8){1'b0}},
                 bus.immed8[5:0], 2'b00};
    first_idx = low_idx(bus.reg_list);
    list_rest = bus.reg_list & (bus.reg_list - 1'b1);
    rem_idx   = low_idx(rem);
    rem_rest  = rem & (rem - 1'b1);
  end

  assign unused_ok = ^{bus.immed7[6:5], bus.immed8[7:6]};

  // Op dispatch and beat sequencer
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      sp      <= SP_RESET;
      addr    <= '0;
      maddr   <= '0;
      pend_sp <= SP_RESET;
      idx     <= '0;
      rem     <= '0;
      we      <= 1'b0;
      re      <= 1'b0;
      bsy     <= 1'b0;
      dn      <= 1'b0;
      flt     <= 1'b0;
    end else begin
      dn  <= 1'b0;
      flt <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            case (bus.op_sel)
              8'h01: begin
                if (n == '0) begin
                  dn <= 1'b1;
                end else if (push_bad) begin
                  dn  <= 1'b1;
                  flt <= 1'b1;
                end else begin
                  state   <= PUSH_SEQ;
                  bsy     <= 1'b1;
                  we      <= 1'b1;
                  maddr   <= dec[DATA_W-1:0];
                  pend_sp <= dec[DATA_W-1:0];
                  idx     <= first_idx;
                  rem     <= list_rest;
                end
              end
              8'h02: begin
                if (n == '0) begin
                  dn <= 1'b1;
                end else if (pop_bad) begin
                  dn  <= 1'b1;
                  flt <= 1'b1;
                end else begin
                  state   <= POP_SEQ;
                  bsy     <= 1'b1;
                  re      <= 1'b1;
                  maddr   <= sp;
                  pend_sp <= inc[DATA_W-1:0];
                  idx     <= first_idx;
                  rem     <= list_rest;
                end
              end
              8'h04: begin
                sp <= sp + off7;
                dn <= 1'b1;
              end
              8'h08: begin
                sp <= sp - off7;
                dn <= 1'b1;
              end
              8'h10: begin
                sp <= bus.data_in;
                dn <= 1'b1;
              end
              8'h20, 8'h40, 8'h80: begin
                addr <= sp + off8;
                dn   <= 1'b1;
              end
              default: dn <= 1'b1;
            endcase
          end
        end
        PUSH_SEQ, POP_SEQ: begin
          if (rem != '0) begin
            maddr <= maddr + DATA_W'(4);
            idx   <= rem_idx;
            rem   <= rem_rest;
          end else begin
            state <= IDLE;
            we    <= 1'b0;
            re    <= 1'b0;
            bsy   <= 1'b0;
            dn    <= 1'b1;
            sp    <= pend_sp;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.sp_out      = sp;
  assign bus.addr_out    = addr;
  assign bus.mem_addr    = maddr;
  assign bus.mem_we      = we;
  assign bus.mem_re      = re;
  assign bus.mem_reg_idx = idx;
  assign bus.busy        = bsy;
  assign bus.done        = dn;
  assign bus.fault       = flt;
endmodule

// File: doc/sp_seq_unit.md
Name: sp_seq_unit

Overview:
- Registered stack-pointer unit; the next generation of the combinational SP datapath.
- Holds SP in a register and sequences multi-register PUSH/POP over one memory beat per cycle.
- Computes SP-relative addresses for ADDS/LDRSP/STRSP.
- Sits between the decoder (op_sel, immediates, register list) and the data-memory port and register file; flags stack overflow and underflow.

Parameters:
- DATA_W, 32: SP and address width.
- NREG, 8: register-list width; mem_reg_idx width is clog2(NREG).
- SP_RESET, 32'h0000_0100: SP value after reset.
- STACK_BASE, 32'h0000_0100: highest legal SP (empty stack).
- STACK_LIMIT, 32'h0000_0080: lowest legal SP (full stack).

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- start  in  1  accept op_sel this cycle; ignored while busy=1.
- op_sel  in  8  one-hot opcode: NOP=00, PUSH=01, POP=02, ADDSP=04, SUBSP=08, MOVSP=10, ADDS=20, LDRSP=40, STRSP=80.
- reg_list  in  NREG  PUSH/POP register mask.
- immed7  in  7  ADDSP/SUBSP offset; bits [4:0] used, scaled by 4.
- immed8  in  8  ADDS/LDRSP/STRSP offset; bits [5:0] used, scaled by 4.
- data_in  in  DATA_W  new SP value for MOVSP.
- sp_out  out  DATA_W  current SP register.
- addr_out  out  DATA_W  registered SP+offset for ADDS/LDRSP/STRSP.
- mem_addr  out  DATA_W  beat address.
- mem_we  out  1  PUSH beat strobe.
- mem_re  out  1  POP beat strobe.
- mem_reg_idx  out  clog2(NREG)  register index of the current beat.
- busy  out  1  sequence in progress.
- done  out  1  one-cycle completion pulse.
- fault  out  1  one-cycle pulse, coincident with done, on overflow/underflow.

Behaviour:
- Reset (rst_n=0 at an edge):
  - sp_out=SP_RESET; addr_out=0; mem_addr=0; mem_reg_idx=0.
  - mem_we, mem_re, busy, done, fault all 0; FSM goes to IDLE.
  - Reset mid-sequence aborts it: no further beats, SP=SP_RESET.
- FSM states: IDLE, PUSH_SEQ, POP_SEQ.
- Single-cycle ops (start accepted in cycle T, registers updated at the end of T, done=1 in T+1):
  - ADDSP: SP += immed7[4:0]<<2.
  - SUBSP: SP -= immed7[4:0]<<2.
  - MOVSP: SP = data_in.
  - ADDS/LDRSP/STRSP: addr_out = SP + (immed8[5:0]<<2); SP unchanged.
  - NOP, or any non-one-hot op_sel: SP unchanged, done pulses.
  - All arithmetic is modulo 2^DATA_W. ADDSP/SUBSP/MOVSP are unchecked and never fault.
- PUSH, with N = popcount(reg_list):
  - N=0: behaves as NOP.
  - SP - 4N < STACK_LIMIT (unsigned) or borrow: fault=1 and done=1 in T+1, no beats, SP unchanged.
  - Otherwise enter PUSH_SEQ with busy=1 in cycles T+1..T+N.
  - Beat k (k=0..N-1) is in cycle T+1+k: mem_we=1, mem_addr = SP-4N+4k, mem_reg_idx = k-th set bit of reg_list in ascending order (lowest register at lowest address).
  - SP = SP-4N at the end of cycle T+N; done=1 in T+N+1; return to IDLE.
- POP, with N = popcount(reg_list):
  - N=0: behaves as NOP.
  - SP + 4N > STACK_BASE or carry: fault=1 and done=1 in T+1, no beats, SP unchanged.
  - Otherwise enter POP_SEQ: beat k has mem_re=1, mem_addr = SP+4k, mem_reg_idx ascending.
  - SP = SP+4N at the end of the last beat; done in T+N+1.
- reg_list and the base SP are latched at accept; input changes during busy have no effect.
- start while busy=1 is dropped, not queued. start may be asserted in the cycle done=1 and is accepted.
- mem_we and mem_re are never high together, and are 0 outside beats.
- Boundaries are inclusive:
  - A PUSH landing exactly on STACK_LIMIT is legal.
  - A POP landing exactly on STACK_BASE is legal.
  - N=NREG produces NREG beats.

Test Plan:
- Reset, then SUBSP immed7=5 -> sp_out=0x100, then 0xEC in the done cycle; ADDSP immed7=5 -> 0x100.
- PUSH reg_list=8'b1000_0101 at SP=0x100 -> beats (idx0,0xF4), (idx2,0xF8), (idx7,0xFC) with mem_we=1; busy for 3 cycles; sp_out=0xF4; done at T+4.
- POP reg_list=8'b1000_0101 at SP=0xF4 -> beats (idx0,0xF4), (idx2,0xF8), (idx7,0xFC) with mem_re=1; sp_out=0x100; done at T+4.
- Faults:
  - POP reg_list=8'h01 at SP=0x100 -> fault=done=1 at T+1, no beats, SP=0x100.
  - MOVSP data_in=0x84, then PUSH reg_list=8'h03 -> fault (0x7C < 0x80).
  - PUSH reg_list=8'h01 at 0x84 -> legal, SP=0x80.
- Reset mid-PUSH (rst_n=0 after beat 1 of a 3-beat push) -> mem_we=0 and busy=0 next cycle, sp_out=0x100; start held during busy in a separate run is ignored.
- LDRSP immed8=0x3F at SP=0x100 -> addr_out=0x1FC, SP unchanged; start with op_sel=8'h03 -> NOP, done pulses, SP unchanged.
